clk_monitor: RTL

Receive-side companion to the clock divider. Samples a divided clock (e.g. clk_alu or clk_1M) in the clk_100M domain and measures its period and high time in clk_100M cycles. Reports each measurement through a valid/ready handshake and flags out-of-tolerance or stuck clocks. Used for on-board self-check of the divider outputs.

---
 rtl/clk_monitor_pkg.sv | 15 +
 rtl/clk_edge_sync.sv | 29 ++
 rtl/clk_monitor.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/clk_monitor_pkg.sv
// Shared types and helpers for the clk_monitor divided-clock checker.
package clk_monitor_pkg;

  localparam int CNT_W_DEFAULT = 16;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] limit);
    return (value >= limit) ? limit : value + 32'd1;
  endfunction

endpackage

// File: rtl/clk_edge_sync.sv
// Brings an asynchronous clock into the local domain and flags its edges.
module clk_edge_sync (
  input  logic clk_100M,
  input  logic rst_n,
  input  logic clk_in,
  output logic rise,
  output logic fall
);

  logic s1_reg;
  logic s2_reg;
  logic s3_reg;

  always_ff @(posedge clk_100M) begin
    if (!rst_n) begin
      s1_reg <= 1'b0;
      s2_reg <= 1'b0;
      s3_reg <= 1'b0;
    end else begin
      s1_reg <= clk_in;
      s2_reg <= s1_reg;
      s3_reg <= s2_reg;
    end
  end

  assign rise = s2_reg & ~s3_reg;
  assign fall = ~s2_reg & s3_reg;

endmodule

// File: rtl/clk_monitor.sv
// Measures period and high time of a divided clock; flags frequency, stuck and overrun.
// Optional duty-cycle check is built when DUTY_CHECK_EN is defined.
module clk_monitor
  import clk_monitor_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEFAULT,
  parameter int EXP_PERIOD = 102,
  parameter int TOL        = 2,
  parameter int TIMEOUT    = 1000
) (
  input  logic             clk_100M,
  input  logic             rst_n,
  input  logic             clk_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic             overrun,
  output logic             freq_ok,
  output logic             stuck,
  output logic             duty_ok
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] PER_LO    = CNT_W'(EXP_PERIOD - TOL);
  localparam logic [CNT_W-1:0] PER_HI    = CNT_W'(EXP_PERIOD + TOL);

  logic rise;
  logic fall;

  clk_edge_sync u_sync (
    .clk_100M (clk_100M),
    .rst_n    (rst_n),
    .clk_in   (clk_in),
    .rise     (rise),
    .fall     (fall)
  );

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic [CNT_W-1:0] high_tmp_reg, high_tmp_next;
  logic [CNT_W-1:0] period_reg, period_next;
  logic [CNT_W-1:0] high_reg, high_next;
  logic             valid_reg, valid_next;
  logic             overrun_reg, overrun_next;
  logic             freq_ok_reg, freq_ok_next;
  logic             stuck_reg, stuck_next;
  logic             meas_take;
  logic             stuck_set;

  always_ff @(posedge clk_100M) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      high_tmp_reg <= '0;
      period_reg   <= '0;
      high_reg     <= '0;
      valid_reg    <= 1'b0;
      overrun_reg  <= 1'b0;
      freq_ok_reg  <= 1'b0;
      stuck_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      high_tmp_reg <= high_tmp_next;
      period_reg   <= period_next;
      high_reg     <= high_next;
      valid_reg    <= valid_next;
      overrun_reg  <= overrun_next;
      freq_ok_reg  <= freq_ok_next;
      stuck_reg    <= stuck_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    high_tmp_next = high_tmp_reg;
    period_next   = period_reg;
    high_next     = high_reg;
    valid_next    = valid_reg;
    overrun_next  = overrun_reg;
    freq_ok_next  = freq_ok_reg;
    stuck_next    = stuck_reg;
    meas_take     = 1'b0;
    stuck_set     = 1'b0;
    cnt_inc       = CNT_W'(sat_inc(32'(cnt_reg), 32'(TIMEOUT_C)));

    // A new measurement in the same cycle overrides the handshake clear below.
    if (valid_reg && meas_ready) valid_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (rise) begin
          state_next = MEASURE;
          cnt_next   = {{(CNT_W-1){1'b0}}, 1'b1};
          stuck_next = 1'b0;
        end else if (cnt_reg == TIMEOUT_C) begin
          stuck_set = 1'b1;
          cnt_next  = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      MEASURE: begin
        if (rise) begin
          meas_take    = 1'b1;
          period_next  = cnt_reg;
          high_next    = high_tmp_reg;
          valid_next   = 1'b1;
          freq_ok_next = (cnt_reg >= PER_LO) && (cnt_reg <= PER_HI);
          if (valid_reg && !meas_ready) overrun_next = 1'b1;
          cnt_next     = {{(CNT_W-1){1'b0}}, 1'b1};
          stuck_next   = 1'b0;
        end else if (cnt_reg == TIMEOUT_C) begin
          stuck_set  = 1'b1;
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
          if (fall) high_tmp_next = cnt_reg;
        end
      end
      default: state_next = IDLE;
    endcase

    if (stuck_set) begin
      stuck_next   = 1'b1;
      freq_ok_next = 1'b0;
    end
  end

`ifdef DUTY_CHECK_EN
  localparam logic signed [CNT_W+1:0] DUTY_LIM = (CNT_W+2)'(2 * TOL);

  logic                    duty_ok_reg, duty_ok_next;
  logic signed [CNT_W+1:0] duty_diff;
  logic signed [CNT_W+1:0] duty_abs;

  always_comb begin
    duty_diff    = $signed({1'b0, high_tmp_reg, 1'b0}) - $signed({2'b00, cnt_reg});
    duty_abs     = (duty_diff < 0) ? -duty_diff : duty_diff;
    duty_ok_next = duty_ok_reg;
    if (meas_take)      duty_ok_next = (duty_abs <= DUTY_LIM);
    else if (stuck_set) duty_ok_next = 1'b0;
  end

  always_ff @(posedge clk_100M) begin
    if (!rst_n) duty_ok_reg <= 1'b0;
    else        duty_ok_reg <= duty_ok_next;
  end

  assign duty_ok = duty_ok_reg;
`else
  assign duty_ok = 1'b0;
`endif

  assign period     = period_reg;
  assign high_time  = high_reg;
  assign meas_valid = valid_reg;
  assign overrun    = overrun_reg;
  assign freq_ok    = freq_ok_reg;
  assign stuck      = stuck_reg;

endmodule
